// File: rtl/poly_decode.sv
// poly_decode -- message decoder following the polynomial adder.
//
// Captures a packed N-coefficient polynomial when poly_valid is high while
// idle. It then decodes LANES coefficients per cycle into message bits by
// quarter-modulus thresholding, and publishes the N-bit message with a
// one-cycle msg_ready pulse.
//
// Optional feature: define POLY_DECODE_RANGE_CHK_EN to build the range check.
// Every coefficient >= P is then flagged, and range_err is updated at FIN.
// When the macro is not defined, no comparators are built and range_err is
// tied to 0.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-low reset
//   poly_in    packed polynomial; coefficient i at bits [i*B +: B]
//   poly_valid capture request (the adder's sum_ready); used only in IDLE
//   busy       high while in DECODE or FIN
//   msg        decoded message; bit i comes from coefficient i
//   msg_ready  one-cycle pulse in the cycle after msg is updated
//   range_err  some coefficient of the last polynomial was >= P
//
// Handshake: poly_valid is a single-cycle request with no ready. It is
// accepted only when busy is low, which includes the cycle where msg_ready
// is high. A request while busy is dropped silently. After the capture edge,
// poly_in may change freely.
//
// Parameter constraints:
//   - LANES must divide N.
//   - LANES must be smaller than N.
module poly_decode #(
  parameter int unsigned P     = 1049089,
  parameter int unsigned N     = 256,
  parameter int unsigned B     = 21,
  parameter int unsigned LANES = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*B-1:0] poly_in,
  input  logic           poly_valid,
  output logic           busy,
  output logic [N-1:0]   msg,
  output logic           msg_ready,
  output logic           range_err
);

  localparam int unsigned T      = P / 2;
  localparam int unsigned T_HALF = T / 2;
  localparam int unsigned CW     = $clog2(N) + 1;

  // The decode window is [LO, HI) in plain unsigned B-bit compares.
  localparam logic [B-1:0]  LO   = B'(T_HALF);
  localparam logic [B-1:0]  HI   = B'(T + T_HALF);
  localparam logic [CW-1:0] LAST = CW'(N - LANES);
  localparam logic [CW-1:0] STEP = CW'(LANES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    FIN    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [N*B-1:0] shadow_q;
  logic [N-1:0]   work_q;
  logic [CW-1:0]  cnt_q;
  logic [LANES-1:0] lane_bit;

  assign busy = (state_q != IDLE);

  // The shadow register shifts down by one lane group per DECODE cycle.
  // The coefficients for the current counter value are therefore always
  // in its low LANES*B bits.
  always_comb begin
    lane_bit = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      lane_bit[l] = (shadow_q[l*B +: B] >= LO) && (shadow_q[l*B +: B] < HI);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (poly_valid) state_d = DECODE;
      DECODE:  if (cnt_q == LAST) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The work register fills from the top. After N/LANES shifts, the bit
  // decoded from coefficient i sits at work_q[i].
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_q  <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      msg       <= '0;
      msg_ready <= 1'b0;
    end else begin
      msg_ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (poly_valid) begin
            shadow_q <= poly_in;
            work_q   <= '0;
            cnt_q    <= '0;
          end
        end
        DECODE: begin
          shadow_q <= shadow_q >> (LANES * B);
          work_q   <= {lane_bit, work_q[N-1:LANES]};
          cnt_q    <= cnt_q + STEP;
        end
        FIN: begin
          msg       <= work_q;
          msg_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef POLY_DECODE_RANGE_CHK_EN
  logic lane_err;
  logic err_acc_q;

  always_comb begin
    lane_err = 1'b0;
    for (int l = 0; l < int'(LANES); l++) begin
      lane_err = lane_err | (shadow_q[l*B +: B] >= B'(P));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_acc_q <= 1'b0;
      range_err <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (poly_valid) err_acc_q <= 1'b0;
        DECODE:  err_acc_q <= err_acc_q | lane_err;
        FIN:     range_err <= err_acc_q;
        default: ;
      endcase
    end
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_poly_decode.sv
// Self-checking bench for poly_decode.
//
// dut1 uses LANES=1 and dut4 uses LANES=4. They share clk and reset.
// Expected messages come from the decode rule applied to the coefficient
// array with plain integer compares.
module tb_poly_decode;

  localparam int N  = 256;
  localparam int B  = 21;
  localparam int NB = N * B;
  localparam int unsigned P      = 1049089;
  localparam int unsigned T      = P / 2;
  localparam int unsigned T_HALF = T / 2;
  localparam int unsigned CMAX   = (1 << B) - 1;
`ifdef POLY_DECODE_RANGE_CHK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NB-1:0] poly_in    [2];
  logic          poly_valid [2];
  logic          busy       [2];
  logic [N-1:0]  msg        [2];
  logic          msg_ready  [2];
  logic          range_err  [2];

  poly_decode #(.LANES(1)) dut1 (
    .clk(clk), .reset(reset), .poly_in(poly_in[0]), .poly_valid(poly_valid[0]),
    .busy(busy[0]), .msg(msg[0]), .msg_ready(msg_ready[0]), .range_err(range_err[0])
  );

  poly_decode #(.LANES(4)) dut4 (
    .clk(clk), .reset(reset), .poly_in(poly_in[1]), .poly_valid(poly_valid[1]),
    .busy(busy[1]), .msg(msg[1]), .msg_ready(msg_ready[1]), .range_err(range_err[1])
  );

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [N-1:0] exp_q [$];
  logic         err_q [$];
  logic [N-1:0] last_msg [2];
  logic         last_err [2];
  int unsigned  coef [N];
  int           e0_cyc = 0;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // ---------------------------------------------------------------- reference model
  function automatic logic [N-1:0] model_msg();
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[i] = (coef[i] >= T_HALF) && (coef[i] < T + T_HALF);
    return m;
  endfunction

  function automatic logic model_err();
    logic e;
    e = 1'b0;
    for (int i = 0; i < N; i++) if (coef[i] >= P) e = 1'b1;
    return RANGE_EN ? e : 1'b0;
  endfunction

  function automatic logic [NB-1:0] pack();
    logic [NB-1:0] p;
    for (int i = 0; i < N; i++) p[i*B +: B] = coef[i][B-1:0];
    return p;
  endfunction

  function automatic logic [NB-1:0] rand_bus();
    logic [NB-1:0] r;
    for (int w = 0; w < NB; w += 32) r[w +: 32] = $urandom();
    return r;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? (N + 1) : (N / 4 + 1);
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_const(input int unsigned v);
    for (int i = 0; i < N; i++) coef[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 4))
        0:       coef[i] = $urandom_range(0, CMAX);
        1:       coef[i] = $urandom_range(T_HALF - 2, T_HALF + 2);
        2:       coef[i] = $urandom_range(T + T_HALF - 3, T + T_HALF + 1);
        3:       coef[i] = $urandom_range(0, P - 1);
        default: coef[i] = $urandom_range(P - 2, P + 2);
      endcase
    end
  endtask

  task automatic send(input int d);
    poly_in[d]    = pack();
    poly_valid[d] = 1'b1;
    tick();
    poly_valid[d] = 1'b0;
    poly_in[d]    = rand_bus();
    e0_cyc = cyc;
    exp_q.push_back(model_msg());
    err_q.push_back(model_err());
    check($sformatf("d%0d_busy_after_capture", d), busy[d], 1'b1);
  endtask

  task automatic wait_done(input int d, input bit check_pulse);
    int lat;
    bit busy_ok;
    bit seen;
    logic [N-1:0] em;
    logic ee;
    lat = lat_of(d);
    busy_ok = 1'b1;
    seen = 1'b0;
    while (!seen && (cyc - e0_cyc) < lat + 20) begin
      tick();
      poly_in[d] = rand_bus();
      if (msg_ready[d]) seen = 1'b1;
      else begin
        if (!busy[d]) busy_ok = 1'b0;
        if ((cyc - e0_cyc) == lat / 2) begin
          check($sformatf("d%0d_msg_hold", d), msg[d], last_msg[d]);
          check($sformatf("d%0d_err_hold", d), range_err[d], last_err[d]);
        end
      end
    end
    em = exp_q.pop_front();
    ee = err_q.pop_front();
    check($sformatf("d%0d_ready_seen", d), seen, 1'b1);
    if (seen) begin
      check($sformatf("d%0d_latency", d), cyc - e0_cyc, lat);
      check($sformatf("d%0d_msg", d), msg[d], em);
      check($sformatf("d%0d_range_err", d), range_err[d], ee);
      check($sformatf("d%0d_busy_at_ready", d), busy[d], 1'b0);
      check($sformatf("d%0d_busy_during", d), busy_ok, 1'b1);
      last_msg[d] = em;
      last_err[d] = ee;
      if (check_pulse) begin
        tick();
        check($sformatf("d%0d_ready_single", d), msg_ready[d], 1'b0);
      end
    end
  endtask

  task automatic check_reset_state(input int d);
    check($sformatf("d%0d_rst_msg", d), msg[d], '0);
    check($sformatf("d%0d_rst_ready", d), msg_ready[d], 1'b0);
    check($sformatf("d%0d_rst_busy", d), busy[d], 1'b0);
    check($sformatf("d%0d_rst_err", d), range_err[d], 1'b0);
  endtask

  task automatic overlap_test(input int d, input int ignore_at);
    fill_const(T);
    send(d);
    repeat (ignore_at - 1) tick();
    fill_const(0);
    poly_in[d]    = pack();
    poly_valid[d] = 1'b1;
    tick();
    poly_valid[d] = 1'b0;
    check($sformatf("d%0d_busy_ignored", d), busy[d], 1'b1);
    wait_done(d, 1'b0);
    // New request in the msg_ready cycle must be accepted.
    fill_const(0);
    send(d);
    check($sformatf("d%0d_ready_after_accept", d), msg_ready[d], 1'b0);
    check($sformatf("d%0d_msg_held_ones", d), msg[d], {N{1'b1}});
    wait_done(d, 1'b1);
  endtask

  // ---------------------------------------------------------------- main sequence
  initial begin
    bit quiet;
    poly_valid[0] = 1'b0;
    poly_valid[1] = 1'b0;
    poly_in[0] = '0;
    poly_in[1] = '0;
    last_msg[0] = '0;
    last_msg[1] = '0;
    last_err[0] = 1'b0;
    last_err[1] = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    check_reset_state(0);
    check_reset_state(1);
    reset = 1'b1;
    tick();

    // All zeros, then all T.
    fill_const(0);
    send(0);
    wait_done(0, 1'b1);
    fill_const(T);
    send(0);
    wait_done(0, 1'b1);

    // Threshold boundaries.
    fill_const(0);
    coef[0] = T_HALF - 1;
    coef[1] = T_HALF;
    coef[2] = T + T_HALF - 1;
    coef[3] = T + T_HALF;
    send(0);
    wait_done(0, 1'b1);
    check("thresh_const", msg[0], 256'h6);

    // Out-of-range coefficients, then a clean polynomial.
    fill_const(0);
    coef[5] = P;
    coef[7] = CMAX;
    send(0);
    wait_done(0, 1'b1);
    check("err_const", range_err[0], RANGE_EN);
    fill_const(0);
    send(0);
    wait_done(0, 1'b1);

    // Mid-operation reset: load all ones first so the clear is visible.
    fill_const(T);
    send(0);
    wait_done(0, 1'b1);
    send(0);
    repeat (99) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_q.delete();
    err_q.delete();
    last_msg[0] = '0;
    last_err[0] = 1'b0;
    check_reset_state(0);
    quiet = 1'b1;
    repeat (300) begin
      tick();
      if (msg_ready[0]) quiet = 1'b0;
    end
    check("rst_no_ready", quiet, 1'b1);
    fill_const(0);
    coef[0] = T_HALF - 1;
    coef[1] = T_HALF;
    coef[2] = T + T_HALF - 1;
    coef[3] = T + T_HALF;
    send(0);
    wait_done(0, 1'b1);

    // Overlapping requests, then random polynomials.
    overlap_test(0, 50);
    repeat (3) begin
      fill_rand();
      send(0);
      wait_done(0, 1'b1);
    end

    // LANES=4 instance.
    overlap_test(1, 20);
    repeat (2) begin
      fill_rand();
      send(1);
      wait_done(1, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
